ball_engine: RTL and testbench

- Pong game-state engine directly upstream of the display renderer.
- Once per video frame it advances the ball, bounces it off the walls and paddles, and detects misses.
- Keeps both players' BCD scores and runs the serve and game-over sequence.
- Outputs are the ball position and score buses in the exact packing the renderer consumes.

---
 rtl/ball_engine.sv | 199 +++++++++++++++++++
 tb/tb_ball_engine.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// Pong game-state engine: per-frame ball motion, wall/paddle bounces, BCD scoring and serve/game-over flow.
// Optional macro SPEEDUP_EN: each paddle reflection raises the x step by one, capped at MAX_SPEED.
module ball_engine #(
  parameter int SPEED       = 4,
  parameter int SPEED_Y     = 2,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 9,
  parameter int MAX_SPEED   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [19:0] ppos,
  output logic [19:0] ball,
  output logic [7:0]  score,
  output logic        game_over
);

  localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY + 1) : 1;

  localparam logic [9:0]    CENTER_X = 10'd324;
  localparam logic [9:0]    CENTER_Y = 10'd303;
  localparam logic [10:0]   TOP_Y    = 11'd137;
  localparam logic [10:0]   BOT_Y    = 11'd470;
  localparam logic [10:0]   STEP_Y   = 11'(SPEED_Y);
  localparam logic [10:0]   STEP_X0  = 11'(SPEED);
  localparam logic [CW-1:0] DELAY    = CW'(SERVE_DELAY);
  localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE    = 2'd1,
    PLAY     = 2'd2,
    GAMEOVER = 2'd3
  } state_t;

  state_t        state_q, state_n;
  logic [9:0]    bx_q, bx_n, by_q, by_n;
  logic          dx_q, dx_n, dy_q, dy_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [10:0]   step_q, step_n, step_bump;
  logic [3:0]    sl_q, sl_n, sr_q, sr_n;
  logic [3:0]    sl_inc, sr_inc;
  logic          go_n;
  logic          pt_l, pt_r;

  logic [10:0] bx_w, by_w, lpad, rpad;
  logic        ovl_l, ovl_r, hit_l, hit_r;

  assign bx_w = {1'b0, bx_q};
  assign by_w = {1'b0, by_q};
  assign lpad = {1'b0, ppos[9:0]};
  assign rpad = {1'b0, ppos[19:10]};

  // Ball rows by-7..by-1 against paddle rows 129+p..175+p, rearranged so nothing subtracts.
  assign ovl_l = (by_w <= lpad + 11'd182) && (by_w >= lpad + 11'd130);
  assign ovl_r = (by_w <= rpad + 11'd182) && (by_w >= rpad + 11'd130);
  assign hit_l = (bx_w > 11'd30) && (bx_w <= step_q + 11'd30) && ovl_l;
  assign hit_r = (bx_w < 11'd618) && (bx_w + step_q >= 11'd618) && ovl_r;

  assign sl_inc = (sl_q >= 4'd9) ? 4'd9 : sl_q + 4'd1;
  assign sr_inc = (sr_q >= 4'd9) ? 4'd9 : sr_q + 4'd1;

`ifdef SPEEDUP_EN
  assign step_bump = (step_q >= 11'(MAX_SPEED)) ? 11'(MAX_SPEED) : step_q + 11'd1;
`else
  assign step_bump = step_q;
`endif

  always_comb begin
    state_n = state_q;
    bx_n    = bx_q;
    by_n    = by_q;
    dx_n    = dx_q;
    dy_n    = dy_q;
    cnt_n   = cnt_q;
    step_n  = step_q;
    sl_n    = sl_q;
    sr_n    = sr_q;
    pt_l    = 1'b0;
    pt_r    = 1'b0;

    case (state_q)
      IDLE, GAMEOVER: begin
        // A valid start swallows any frame_tick arriving in the same cycle.
        if (start) begin
          state_n = SERVE;
          sl_n    = 4'd0;
          sr_n    = 4'd0;
          dx_n    = 1'b1;
          cnt_n   = DELAY;
          step_n  = STEP_X0;
          bx_n    = CENTER_X;
          by_n    = CENTER_Y;
        end
      end

      SERVE: begin
        if (frame_tick) begin
          if (cnt_q == '0) state_n = PLAY;
          else             cnt_n   = cnt_q - 1'b1;
        end
      end

      PLAY: begin
        if (frame_tick) begin
          if (dy_q) begin
            if (by_w + STEP_Y > BOT_Y) begin
              by_n = BOT_Y[9:0];
              dy_n = 1'b0;
            end else begin
              by_n = 10'(by_w + STEP_Y);
            end
          end else begin
            if (by_w < TOP_Y + STEP_Y) begin
              by_n = TOP_Y[9:0];
              dy_n = 1'b1;
            end else begin
              by_n = 10'(by_w - STEP_Y);
            end
          end

          if (dx_q) begin
            if (hit_r) begin
              bx_n   = 10'd617;
              dx_n   = 1'b0;
              step_n = step_bump;
            end else if (bx_w + step_q > 11'd639) begin
              pt_l = 1'b1;
            end else begin
              bx_n = 10'(bx_w + step_q);
            end
          end else begin
            if (hit_l) begin
              bx_n   = 10'd31;
              dx_n   = 1'b1;
              step_n = step_bump;
            end else if (bx_w < step_q + 11'd8) begin
              pt_r = 1'b1;
            end else begin
              bx_n = 10'(bx_w - step_q);
            end
          end

          // A miss recentres the ball and serves toward the player who lost the point.
          if (pt_l || pt_r) begin
            bx_n = CENTER_X;
            by_n = CENTER_Y;
            dx_n = pt_l;
            if (pt_l) sl_n = sl_inc;
            else      sr_n = sr_inc;
            if ((pt_l && sl_inc == WIN) || (pt_r && sr_inc == WIN)) begin
              state_n = GAMEOVER;
            end else begin
              state_n = SERVE;
              cnt_n   = DELAY;
              step_n  = STEP_X0;
            end
          end
        end
      end

      default: state_n = IDLE;
    endcase

    go_n = (state_n == GAMEOVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bx_q      <= CENTER_X;
      by_q      <= CENTER_Y;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      cnt_q     <= '0;
      step_q    <= STEP_X0;
      sl_q      <= 4'd0;
      sr_q      <= 4'd0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_n;
      bx_q      <= bx_n;
      by_q      <= by_n;
      dx_q      <= dx_n;
      dy_q      <= dy_n;
      cnt_q     <= cnt_n;
      step_q    <= step_n;
      sl_q      <= sl_n;
      sr_q      <= sr_n;
      game_over <= go_n;
    end
  end

  assign ball  = {by_q, bx_q};
  assign score = {sr_q, sl_q};

endmodule

// File: tb/tb_ball_engine.sv
// Randomised self-checking bench for ball_engine against a frame-level game model.
module tb_ball_engine;

  localparam int SPEED       = 4;
  localparam int SPEED_Y     = 2;
  localparam int SERVE_DELAY = 60;
  localparam int WIN_SCORE   = 9;
  localparam int MAX_SPEED   = 8;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_OVER  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [19:0] ppos = '0;
  logic [19:0] ball;
  logic [7:0]  score;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  int m_st, m_bx, m_by, m_cnt, m_step, m_sl, m_sr;
  bit m_dx, m_dy;

  ball_engine #(
    .SPEED(SPEED), .SPEED_Y(SPEED_Y), .SERVE_DELAY(SERVE_DELAY),
    .WIN_SCORE(WIN_SCORE), .MAX_SPEED(MAX_SPEED)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .ppos(ppos), .ball(ball), .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_point(input bit left_scored);
    if (left_scored) m_sl = (m_sl >= 9) ? 9 : m_sl + 1;
    else             m_sr = (m_sr >= 9) ? 9 : m_sr + 1;
    m_bx = 324;
    m_by = 303;
    m_dx = left_scored;
    if ((left_scored ? m_sl : m_sr) == WIN_SCORE) m_st = M_OVER;
    else begin
      m_st = M_SERVE;
      m_cnt = SERVE_DELAY;
      m_step = SPEED;
    end
  endtask

  task automatic model_bump();
`ifdef SPEEDUP_EN
    if (m_step < MAX_SPEED) m_step++;
`endif
  endtask

  // One clock edge of game behaviour, written straight from the game rules.
  task automatic model_step(input bit r, input bit s, input bit t, input logic [19:0] p);
    int lp, rp;
    bit lov, rov;
    lp = int'(p[9:0]);
    rp = int'(p[19:10]);
    if (r) begin
      m_st = M_IDLE; m_bx = 324; m_by = 303; m_sl = 0; m_sr = 0;
      m_dx = 1; m_dy = 1; m_cnt = 0; m_step = SPEED;
      return;
    end
    if (s && (m_st == M_IDLE || m_st == M_OVER)) begin
      m_sl = 0; m_sr = 0; m_dx = 1; m_st = M_SERVE; m_cnt = SERVE_DELAY;
      m_step = SPEED; m_bx = 324; m_by = 303;
      return;
    end
    if (!t) return;
    if (m_st == M_SERVE) begin
      if (m_cnt == 0) m_st = M_PLAY;
      else m_cnt--;
      return;
    end
    if (m_st != M_PLAY) return;
    lov = (m_by - 7 <= 175 + lp) && (m_by - 1 >= 129 + lp);
    rov = (m_by - 7 <= 175 + rp) && (m_by - 1 >= 129 + rp);
    if (m_dy) begin
      if (m_by + SPEED_Y > 470) begin m_by = 470; m_dy = 0; end
      else m_by += SPEED_Y;
    end else begin
      if (m_by - SPEED_Y < 137) begin m_by = 137; m_dy = 1; end
      else m_by -= SPEED_Y;
    end
    if (!m_dx) begin
      if (m_bx - 7 > 23 && m_bx - m_step - 7 <= 23 && lov) begin
        m_bx = 31; m_dx = 1; model_bump();
      end else if (m_bx < m_step + 8) model_point(0);
      else m_bx -= m_step;
    end else begin
      if (m_bx - 1 < 617 && m_bx + m_step - 1 >= 617 && rov) begin
        m_bx = 617; m_dx = 0; model_bump();
      end else if (m_bx + m_step > 639) model_point(1);
      else m_bx += m_step;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit t, input logic [19:0] p);
    logic [19:0] exp_ball;
    logic [7:0]  exp_score;
    rst = r; start = s; frame_tick = t; ppos = p;
    model_step(r, s, t, p);
    @(posedge clk);
    #1;
    exp_ball  = 20'(m_by * 1024 + m_bx);
    exp_score = 8'(m_sr * 16 + m_sl);
    checkOutput("ball", 32'(ball), 32'(exp_ball));
    checkOutput("score", 32'(score), 32'(exp_score));
    checkOutput("game_over", 32'(game_over), 32'(m_st == M_OVER));
  endtask

  // Mostly tracks the ball so rallies happen, sometimes random so points get scored.
  function automatic logic [9:0] gen_pad(input int by);
    int v;
    if ($urandom_range(0, 3) == 0) return 10'($urandom_range(0, 1023));
    v = by - 156 + int'($urandom_range(0, 60)) - 30;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return 10'(v);
  endfunction

  initial begin
    logic [19:0] p;
    int guard;
    bit saw_over;
    saw_over = 0;

    applyStimulus(1, 0, 0, '0);
    applyStimulus(1, 0, 1, '0);
    checkOutput("reset_ball", 32'(ball), 32'({10'd303, 10'd324}));
    checkOutput("reset_score", 32'(score), 32'h00);
    checkOutput("reset_go", 32'(game_over), 32'h0);

    applyStimulus(0, 1, 1, '0);
    for (int i = 0; i < SERVE_DELAY + 1; i++) applyStimulus(0, 0, 1, '0);
    checkOutput("serve_hold", 32'(ball), 32'({10'd303, 10'd324}));
    applyStimulus(0, 0, 1, '0);
    checkOutput("first_move", 32'(ball), 32'({10'd305, 10'd328}));

    for (int c = 0; c < 60000; c++) begin
      p = {gen_pad(m_by), gen_pad(m_by)};
      applyStimulus($urandom_range(0, 19999) == 0,
                    $urandom_range(0, 199) == 0,
                    $urandom_range(0, 1) == 0, p);
      if (m_st == M_OVER) saw_over = 1;
    end
    checkOutput("reached_gameover", 32'(saw_over), 32'h1);

    guard = 0;
    while (m_st != M_PLAY && guard < 2000) begin
      applyStimulus(0, m_st != M_SERVE, 1, {gen_pad(m_by), gen_pad(m_by)});
      guard++;
    end
    checkOutput("reach_play", 32'(m_st == M_PLAY), 32'h1);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, {gen_pad(m_by), gen_pad(m_by)});
    applyStimulus(1, 0, 1, '0);
    checkOutput("midplay_rst_ball", 32'(ball), 32'({10'd303, 10'd324}));
    checkOutput("midplay_rst_score", 32'(score), 32'h00);
    checkOutput("midplay_rst_go", 32'(game_over), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
